card_draw_scheduler: RTL

//   Shares the single vga_adapter write port among N_OBJ card-drawing objects.

---
 rtl/card_draw_scheduler_pkg.sv | 14 +
 rtl/card_draw_scheduler_if.sv | 34 +++
 rtl/card_draw_scheduler_rr_picker.sv | 30 +++
 rtl/card_draw_scheduler.sv | 119 +++++++++++
 4 files changed

// File: rtl/card_draw_scheduler_pkg.sv
// Shared defaults and FSM encoding for the card-draw scheduler.
package card_draw_scheduler_pkg;
  localparam int N_OBJ_D       = 16;
  localparam int COLOR_DEPTH_D = 6;
  localparam int XW_D          = 10;
  localparam int YW_D          = 9;
  localparam int TIMEOUT_D     = 8192;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2
  } state_t;
endpackage

// File: rtl/card_draw_scheduler_if.sv
// Object-array <-> scheduler <-> vga_adapter signal bundle.
interface card_draw_scheduler_if #(
  parameter int N_OBJ       = 16,
  parameter int COLOR_DEPTH = 6,
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int IW          = $clog2(N_OBJ)
);
  logic                         redraw_all;
  logic [N_OBJ-1:0]             req;
  logic [N_OBJ-1:0]             inst_done;
  logic [N_OBJ-1:0]             inst_write;
  logic [N_OBJ*XW-1:0]          inst_x_bus;
  logic [N_OBJ*YW-1:0]          inst_y_bus;
  logic [N_OBJ*COLOR_DEPTH-1:0] inst_color_bus;
  logic [N_OBJ-1:0]             inst_go;
  logic [XW-1:0]                vga_x;
  logic [YW-1:0]                vga_y;
  logic [COLOR_DEPTH-1:0]       vga_color;
  logic                         vga_plot;
  logic                         busy;
  logic [IW-1:0]                cur_idx;
  logic                         timeout_err;

  modport master (
    output redraw_all, req, inst_done, inst_write, inst_x_bus, inst_y_bus, inst_color_bus,
    input  inst_go, vga_x, vga_y, vga_color, vga_plot, busy, cur_idx, timeout_err
  );

  modport slave (
    input  redraw_all, req, inst_done, inst_write, inst_x_bus, inst_y_bus, inst_color_bus,
    output inst_go, vga_x, vga_y, vga_color, vga_plot, busy, cur_idx, timeout_err
  );
endinterface

// File: rtl/card_draw_scheduler_rr_picker.sv
// Round-robin priority encoder: first set pending bit at or after rr_ptr, wrapping.
module card_rr_picker #(
  parameter int N_OBJ = 16
) (
  input  logic [N_OBJ-1:0]         pending,
  input  logic [$clog2(N_OBJ)-1:0] rr_ptr,
  output logic                     valid,
  output logic [$clog2(N_OBJ)-1:0] idx
);
  localparam int IW = $clog2(N_OBJ);

  logic [2*N_OBJ-1:0] dbl;
  logic [N_OBJ-1:0]   rot;
  logic [IW:0]        off;
  logic [IW:0]        sum;

  always_comb begin
    // Rotating a doubled copy keeps the wrap handling free of modulo logic.
    dbl   = {pending, pending} >> rr_ptr;
    rot   = dbl[N_OBJ-1:0];
    valid = |rot;
    off   = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (rot[i]) off = (IW+1)'(i);
    end
    sum = off + {1'b0, rr_ptr};
    if (sum >= (IW+1)'(N_OBJ)) idx = IW'(sum - (IW+1)'(N_OBJ));
    else                       idx = IW'(sum);
  end
endmodule

// File: rtl/card_draw_scheduler.sv
// Arbitrates the single VGA write port among the card objects, one grant at a time.
module card_draw_scheduler
  import card_draw_scheduler_pkg::*;
#(
  parameter int N_OBJ       = N_OBJ_D,
  parameter int COLOR_DEPTH = COLOR_DEPTH_D,
  parameter int XW          = XW_D,
  parameter int YW          = YW_D,
  parameter int TIMEOUT     = TIMEOUT_D
) (
  input logic                  clk,
  input logic                  rst,
  card_draw_scheduler_if.slave bus
);
  localparam int IW = $clog2(N_OBJ);
  localparam int TW = $clog2(TIMEOUT);

  state_t                 state, state_nxt;
  logic [N_OBJ-1:0]       pending, clr, go;
  logic [IW-1:0]          rr_ptr, cur_idx, pick_idx, next_ptr;
  logic                   pick_vld;
  logic [TW-1:0]          timer;
  logic                   done_cur, timeout_hit;
  logic                   busy, timeout_err;
  logic [XW-1:0]          vga_x;
  logic [YW-1:0]          vga_y;
  logic [COLOR_DEPTH-1:0] vga_color;
  logic                   vga_plot;

  card_rr_picker #(.N_OBJ(N_OBJ)) u_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .valid   (pick_vld),
    .idx     (pick_idx)
  );

  assign done_cur    = bus.inst_done[cur_idx];
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign next_ptr    = (cur_idx == IW'(N_OBJ - 1)) ? '0 : cur_idx + 1'b1;
  assign clr         = (state == GRANT) ? ({{(N_OBJ-1){1'b0}}, 1'b1} << cur_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_vld) state_nxt = GRANT;
      GRANT:   state_nxt = WAIT;
      WAIT:    if (done_cur || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done beats timeout when both land in the same cycle
  always_comb begin
    go          = '0;
    busy        = 1'b0;
    timeout_err = 1'b0;
    case (state)
      GRANT: begin
        go[cur_idx] = 1'b1;
        busy        = 1'b1;
      end
      WAIT: begin
        busy        = 1'b1;
        timeout_err = timeout_hit && !done_cur;
      end
      default: ;
    endcase
  end

  // A new request in the same cycle as the grant's clear keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      rr_ptr  <= '0;
      cur_idx <= '0;
      timer   <= '0;
    end else begin
      pending <= (pending & ~clr) | bus.req | {N_OBJ{bus.redraw_all}};
      if (state == IDLE && pick_vld) cur_idx <= pick_idx;
      if (state == GRANT)                     timer <= '0;
      else if (state == WAIT && !timeout_hit) timer <= timer + 1'b1;
      if (state == WAIT && (done_cur || timeout_hit)) rr_ptr <= next_ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
      vga_plot  <= 1'b0;
    end else begin
      if (state == WAIT) begin
        vga_x     <= bus.inst_x_bus[int'(cur_idx)*XW +: XW];
        vga_y     <= bus.inst_y_bus[int'(cur_idx)*YW +: YW];
        vga_color <= bus.inst_color_bus[int'(cur_idx)*COLOR_DEPTH +: COLOR_DEPTH];
      end else begin
        vga_x     <= '0;
        vga_y     <= '0;
        vga_color <= '0;
      end
      vga_plot <= bus.inst_write[cur_idx] && (state == WAIT);
    end
  end

  assign bus.inst_go     = go;
  assign bus.busy        = busy;
  assign bus.timeout_err = timeout_err;
  assign bus.cur_idx     = cur_idx;
  assign bus.vga_x       = vga_x;
  assign bus.vga_y       = vga_y;
  assign bus.vga_color   = vga_color;
  assign bus.vga_plot    = vga_plot;
endmodule
